best_move_select: RTL and testbench
===================================

Name: best_move_select

Overview:
- Sits directly downstream of all_moves and consumes its move list.
- After all_moves reports moves ready, the block walks am_move_index across every generated move and reads eval_out/uci_out from the move RAM.
- It picks the best move for the side to move (white maximises, black minimises) and then pulses am_clear_moves to release all_moves.
- It reports the winning index, UCI and eval, or a terminal result when the position has no moves. Used as the one-ply move picker under the search controller.

Parameters:
- MAX_POSITIONS_LOG2, 8, width of move index/count.
- EVAL_WIDTH, 22, signed eval width.
- UCI_WIDTH, 16, {promotion, to, from}.
- RAM_LATENCY, 2, cycles from am_move_index change to valid eval_out/uci_out (min 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  single-cycle request to select from the current move list
- white_to_move  in  1  side to move, sampled on accepted start
- am_moves_ready  in  1  from all_moves: list complete
- am_move_count  in  MAX_POSITIONS_LOG2  from all_moves
- initial_mate  in  1  from all_moves
- initial_stalemate  in  1  from all_moves
- initial_eval  in  EVAL_WIDTH signed  from all_moves
- eval_out  in  EVAL_WIDTH signed  move RAM eval at am_move_index
- uci_out  in  UCI_WIDTH  move RAM uci at am_move_index
- thrice_rep_out  in  1  move RAM repetition flag
- fifty_move_out  in  1  move RAM fifty-move flag
- am_move_index  out  MAX_POSITIONS_LOG2  to all_moves
- am_clear_moves  out  1  to all_moves, one-cycle pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- best_valid  out  1  a move was selected
- best_index  out  MAX_POSITIONS_LOG2  winning move index
- best_uci  out  UCI_WIDTH  winning move
- best_eval  out  EVAL_WIDTH signed  winning eval (or initial_eval if no moves)
- result  out  2  0 = move, 1 = checkmate, 2 = stalemate, 3 = draw/no move otherwise

Behaviour:
- Reset value of every output is 0. Reset asserted mid-operation aborts immediately to IDLE; no am_clear_moves pulse is issued.
- start is accepted only in IDLE; it is ignored while busy.
- States:
  - IDLE: on start, latch white_to_move, clear best_valid, go to WAIT_READY.
  - WAIT_READY: hold am_move_index = 0. On am_moves_ready, latch count = am_move_count.
    - count == 0: best_eval = initial_eval; result = 1 if initial_mate, else 2 if initial_stalemate, else 3; go to CLEAR.
    - Otherwise go to WAIT with a latency counter of RAM_LATENCY.
  - WAIT: decrement the counter. At 0 go to COMPARE.
  - COMPARE: score = 0 if thrice_rep_out or fifty_move_out, else eval_out. Replace best if index == 0, or if (white and score > best_eval) or (black and score < best_eval). Comparison is strict, so a tie keeps the lower index. On replace, capture best_index, best_uci, best_eval, set best_valid = 1 and result = 0. Then:
    - if index + 1 < count: increment am_move_index and go to WAIT;
    - else go to CLEAR.
  - CLEAR: am_clear_moves = 1 for exactly one cycle, am_move_index = 0, go to FLUSH.
  - FLUSH: one wait cycle, done = 1, busy = 0, go to IDLE.
- Per-move cost is RAM_LATENCY + 1 cycles. For N > 0 moves the total from am_moves_ready to done is 1 + N·(RAM_LATENCY + 1) + 2 cycles.
- best_* and result hold their values from done until the next accepted start.
- Comparison is signed; there is no saturation.
- am_move_index never reaches count, so there is no wrap-around. count = 2^MAX_POSITIONS_LOG2 − 1 must work.

Test Plan:
- White, 3 moves with evals {10, 40, 40} -> best_index = 1, best_eval = 40, result = 0, exactly one am_clear_moves pulse, done 1 + 3·3 + 2 = 12 cycles after am_moves_ready.
- Black, evals {−5, −200, 300} -> best_index = 1, best_eval = −200, best_uci = RAM entry 1.
- Black, evals {−50, −80} with thrice_rep_out set on entry 1 -> entry 1 scores 0; best_index = 0, best_eval = −50.
- count = 0, initial_mate = 1, initial_eval = −999999 -> result = 1, best_valid = 0, best_eval = −999999, am_clear_moves pulse, then done.
- count = 0, both initial flags 0 -> result = 3.
- start repeated while busy -> ignored. Drop reset to 0 during WAIT -> all outputs 0, state IDLE, no am_clear_moves pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/best_move_select.sv
// One-ply move picker: walks the all_moves RAM, keeps the best eval for the side to move, then releases all_moves.
// Latency 1 + N*(RAM_LATENCY+1) + 2 cycles from am_moves_ready to done; start is ignored while busy.
module best_move_select #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int EVAL_WIDTH         = 22,
  parameter int UCI_WIDTH          = 16,
  parameter int RAM_LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          white_to_move,
  input  logic                          am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  input  logic                          initial_mate,
  input  logic                          initial_stalemate,
  input  logic signed [EVAL_WIDTH-1:0]  initial_eval,
  input  logic signed [EVAL_WIDTH-1:0]  eval_out,
  input  logic [UCI_WIDTH-1:0]          uci_out,
  input  logic                          thrice_rep_out,
  input  logic                          fifty_move_out,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  output logic                          am_clear_moves,
  output logic                          busy,
  output logic                          done,
  output logic                          best_valid,
  output logic [MAX_POSITIONS_LOG2-1:0] best_index,
  output logic [UCI_WIDTH-1:0]          best_uci,
  output logic signed [EVAL_WIDTH-1:0]  best_eval,
  output logic [1:0]                    result
);

  localparam int IW    = MAX_POSITIONS_LOG2;
  localparam int LAT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LATENCY);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_WAIT       = 3'd2;
  localparam logic [2:0] S_COMPARE    = 3'd3;
  localparam logic [2:0] S_CLEAR      = 3'd4;
  localparam logic [2:0] S_FLUSH      = 3'd5;

  logic [2:0]                   state_q, state_d;
  logic                         white_q, white_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [IW-1:0]                count_q, count_d;
  logic [LAT_W-1:0]             lat_q, lat_d;
  logic                         best_valid_q, best_valid_d;
  logic [IW-1:0]                best_index_q, best_index_d;
  logic [UCI_WIDTH-1:0]         best_uci_q, best_uci_d;
  logic signed [EVAL_WIDTH-1:0] best_eval_q, best_eval_d;
  logic [1:0]                   result_q, result_d;

  logic signed [EVAL_WIDTH-1:0] score;
  logic                         replace;
  logic [IW:0]                  idx_next;

  always_comb begin
    state_d      = state_q;
    white_d      = white_q;
    idx_d        = idx_q;
    count_d      = count_q;
    lat_d        = lat_q;
    best_valid_d = best_valid_q;
    best_index_d = best_index_q;
    best_uci_d   = best_uci_q;
    best_eval_d  = best_eval_q;
    result_d     = result_q;

    // Repetition and fifty-move draws are worth exactly zero to either side.
    score    = (thrice_rep_out || fifty_move_out) ? '0 : eval_out;
    replace  = (idx_q == '0) || (white_q ? (score > best_eval_q) : (score < best_eval_q));
    idx_next = {1'b0, idx_q} + (IW+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          white_d      = white_to_move;
          best_valid_d = 1'b0;
          state_d      = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        idx_d = '0;
        if (am_moves_ready) begin
          count_d = am_move_count;
          if (am_move_count == '0) begin
            best_eval_d = initial_eval;
            result_d    = initial_mate ? 2'd1 : (initial_stalemate ? 2'd2 : 2'd3);
            state_d     = S_CLEAR;
          end else begin
            lat_d   = LAT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LAT_W'(1)) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (replace) begin
          best_index_d = idx_q;
          best_uci_d   = uci_out;
          best_eval_d  = score;
          best_valid_d = 1'b1;
          result_d     = 2'd0;
        end
        if (idx_next < {1'b0, count_q}) begin
          idx_d   = idx_next[IW-1:0];
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end else begin
          idx_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      white_q      <= 1'b0;
      idx_q        <= '0;
      count_q      <= '0;
      lat_q        <= '0;
      best_valid_q <= 1'b0;
      best_index_q <= '0;
      best_uci_q   <= '0;
      best_eval_q  <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      white_q      <= white_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      lat_q        <= lat_d;
      best_valid_q <= best_valid_d;
      best_index_q <= best_index_d;
      best_uci_q   <= best_uci_d;
      best_eval_q  <= best_eval_d;
      result_q     <= result_d;
    end
  end

  assign am_move_index  = idx_q;
  assign am_clear_moves = (state_q == S_CLEAR);
  assign done           = (state_q == S_FLUSH);
  assign busy           = (state_q == S_WAIT_READY) || (state_q == S_WAIT) ||
                          (state_q == S_COMPARE) || (state_q == S_CLEAR);
  assign best_valid     = best_valid_q;
  assign best_index     = best_index_q;
  assign best_uci       = best_uci_q;
  assign best_eval      = best_eval_q;
  assign result         = result_q;

endmodule

// File: tb/tb_best_move_select.sv
// Scoreboard bench for best_move_select with a behavioural all_moves / move-RAM model.
`timescale 1ns/1ps
module tb_best_move_select;
  localparam int MPL = 8;
  localparam int EW  = 22;
  localparam int UW  = 16;
  localparam int RL  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic white_to_move = 1'b0;
  logic am_moves_ready = 1'b0;
  logic [MPL-1:0] am_move_count = '0;
  logic initial_mate = 1'b0;
  logic initial_stalemate = 1'b0;
  logic signed [EW-1:0] initial_eval = '0;
  logic signed [EW-1:0] eval_out;
  logic [UW-1:0] uci_out;
  logic thrice_rep_out, fifty_move_out;
  logic [MPL-1:0] am_move_index;
  logic am_clear_moves, busy, done, best_valid;
  logic [MPL-1:0] best_index;
  logic [UW-1:0] best_uci;
  logic signed [EW-1:0] best_eval;
  logic [1:0] result;

  best_move_select #(.MAX_POSITIONS_LOG2(MPL), .EVAL_WIDTH(EW), .UCI_WIDTH(UW), .RAM_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .white_to_move(white_to_move),
    .am_moves_ready(am_moves_ready), .am_move_count(am_move_count),
    .initial_mate(initial_mate), .initial_stalemate(initial_stalemate), .initial_eval(initial_eval),
    .eval_out(eval_out), .uci_out(uci_out), .thrice_rep_out(thrice_rep_out), .fifty_move_out(fifty_move_out),
    .am_move_index(am_move_index), .am_clear_moves(am_clear_moves), .busy(busy), .done(done),
    .best_valid(best_valid), .best_index(best_index), .best_uci(best_uci), .best_eval(best_eval),
    .result(result)
  );

  always #5 clk = ~clk;

  // Move RAM with RL cycles of read latency from am_move_index.
  logic signed [EW-1:0] ram_eval [256];
  logic [UW-1:0]        ram_uci  [256];
  logic                 ram_rep  [256];
  logic                 ram_fifty[256];
  logic [MPL-1:0]       pipe     [RL];

  always @(posedge clk) begin
    pipe[0] <= am_move_index;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign eval_out       = ram_eval[pipe[RL-1]];
  assign uci_out        = ram_uci[pipe[RL-1]];
  assign thrice_rep_out = ram_rep[pipe[RL-1]];
  assign fifty_move_out = ram_fifty[pipe[RL-1]];

  int clear_cnt = 0;
  int done_cnt  = 0;
  always @(negedge clk) begin
    if (am_clear_moves === 1'b1) clear_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic                 valid;
    logic [MPL-1:0]       idx;
    logic [UW-1:0]        uci;
    logic signed [EW-1:0] ev;
    logic [1:0]           res;
    int                   cycles;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passed = 0;

  task automatic load_case(input int id, output logic white, output int n);
    exp_t e;
    int v;
    logic signed [EW-1:0] bs;
    logic signed [EW-1:0] s;
    for (int i = 0; i < 256; i++) begin
      ram_eval[i]  = '0;
      ram_uci[i]   = UW'((i * 7 + id * 301 + 16'h0123) & 16'hffff);
      ram_rep[i]   = 1'b0;
      ram_fifty[i] = 1'b0;
    end
    e.idx = '0;
    e.ev  = '0;
    case (id)
      0: begin white = 1'b1; n = 3; ram_eval[0] = 10; ram_eval[1] = 40; ram_eval[2] = 40; e.idx = 1; e.ev = 40; end
      1: begin white = 1'b0; n = 3; ram_eval[0] = -5; ram_eval[1] = -200; ram_eval[2] = 300; e.idx = 1; e.ev = -200; end
      2: begin white = 1'b0; n = 2; ram_eval[0] = -50; ram_eval[1] = -80; ram_rep[1] = 1'b1; e.idx = 0; e.ev = -50; end
      3: begin white = 1'b1; n = 3; ram_eval[0] = -7; ram_eval[1] = 100; ram_fifty[1] = 1'b1; ram_eval[2] = -3;
               e.idx = 1; e.ev = 0; end
      4: begin white = 1'b1; n = 4; ram_eval[0] = -100; ram_eval[1] = -30; ram_eval[2] = -60; ram_eval[3] = -30;
               e.idx = 1; e.ev = -30; end
      5: begin white = 1'b0; n = 1; ram_eval[0] = 123; e.idx = 0; e.ev = 123; end
      default: begin
        white = id[0];
        n = 255;
        for (int i = 0; i < n; i++) begin
          v = int'($urandom_range(1000000)) - 500000;
          ram_eval[i] = EW'(v);
          ram_fifty[i] = ($urandom_range(15) == 0);
        end
        ram_eval[254]  = white ? 22'sd2097151 : -22'sd2097152;
        ram_fifty[254] = 1'b0;
        bs = '0;
        for (int k = 0; k < n; k++) begin
          s = (ram_rep[k] || ram_fifty[k]) ? '0 : ram_eval[k];
          if (k == 0 || (white ? (s > bs) : (s < bs))) begin
            bs = s;
            e.idx = MPL'(k);
          end
        end
        e.ev = bs;
      end
    endcase
    e.valid  = 1'b1;
    e.res    = 2'd0;
    e.uci    = ram_uci[e.idx];
    e.cycles = 1 + n * (RL + 1) + 2;
    sb.push_back(e);
  endtask

  // Drives one selection; cycles counts negedges with the am_moves_ready cycle as cycle 1.
  task automatic run_select(input logic white, input int n, input bit dbl,
                            output int cycles, output int clears, output logic busy_wait, output bit timeout);
    int c0;
    @(posedge clk); #1;
    white_to_move = white;
    am_move_count = MPL'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (dbl) begin
      repeat (2) begin
        start = 1'b1;
        white_to_move = ~white;
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    @(negedge clk);
    busy_wait = busy;
    @(posedge clk); #1;
    am_moves_ready = 1'b1;
    c0 = clear_cnt;
    cycles = 0;
    timeout = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      cycles++;
      if (dbl && cycles == 4) begin start = 1'b1; white_to_move = ~white; end
      if (dbl && cycles == 5) start = 1'b0;
      if (done === 1'b1) begin timeout = 1'b0; break; end
    end
    clears = clear_cnt - c0;
    start = 1'b0;
    @(posedge clk); #1;
    am_moves_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (am_move_index !== '0) $display("FAIL reset_index got %0d want 0", am_move_index); else passed++;
    checks++; if ({am_clear_moves, busy, done, best_valid} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {am_clear_moves, busy, done, best_valid}); else passed++;
    checks++; if ({best_index, best_uci, best_eval, result} !== '0) $display("FAIL reset_best got %h want 0", {best_index, best_uci, best_eval, result}); else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_select_cases();
    logic white, bw;
    int n, cyc, clr;
    bit to;
    exp_t e;
    for (int id = 0; id < 8; id++) begin
      load_case(id, white, n);
      run_select(white, n, 1'b0, cyc, clr, bw, to);
      e = sb.pop_front();
      checks++; if (to) $display("FAIL sel%0d_timeout no done within budget", id); else passed++;
      checks++; if (best_valid !== e.valid) $display("FAIL sel%0d_valid got %b want %b", id, best_valid, e.valid); else passed++;
      checks++; if (best_index !== e.idx) $display("FAIL sel%0d_index got %0d want %0d", id, best_index, e.idx); else passed++;
      checks++; if (best_uci !== e.uci) $display("FAIL sel%0d_uci got %h want %h", id, best_uci, e.uci); else passed++;
      checks++; if (best_eval !== e.ev) $display("FAIL sel%0d_eval got %0d want %0d", id, best_eval, e.ev); else passed++;
      checks++; if (result !== e.res) $display("FAIL sel%0d_result got %0d want %0d", id, result, e.res); else passed++;
      checks++; if (cyc != e.cycles) $display("FAIL sel%0d_latency got %0d want %0d", id, cyc, e.cycles); else passed++;
      checks++; if (clr != 1) $display("FAIL sel%0d_clear_pulses got %0d want 1", id, clr); else passed++;
      checks++; if (bw !== 1'b1) $display("FAIL sel%0d_busy got %b want 1", id, bw); else passed++;
    end
  endtask

  task automatic test_no_moves();
    logic bw;
    int cyc, clr;
    bit to;
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      initial_mate      = (t == 0);
      initial_stalemate = (t == 1);
      initial_eval      = (t == 0) ? -22'sd999999 : ((t == 1) ? 22'sd17 : 22'sd5);
      e.valid = 1'b0; e.idx = '0; e.uci = '0; e.ev = initial_eval;
      e.res = (t == 0) ? 2'd1 : ((t == 1) ? 2'd2 : 2'd3);
      e.cycles = 3;
      sb.push_back(e);
      run_select(1'b1, 0, 1'b0, cyc, clr, bw, to);
      e = sb.pop_front();
      checks++; if (to) $display("FAIL nomove%0d_timeout no done within budget", t); else passed++;
      checks++; if (best_valid !== e.valid) $display("FAIL nomove%0d_valid got %b want %b", t, best_valid, e.valid); else passed++;
      checks++; if (best_eval !== e.ev) $display("FAIL nomove%0d_eval got %0d want %0d", t, best_eval, e.ev); else passed++;
      checks++; if (result !== e.res) $display("FAIL nomove%0d_result got %0d want %0d", t, result, e.res); else passed++;
      checks++; if (cyc != e.cycles) $display("FAIL nomove%0d_latency got %0d want %0d", t, cyc, e.cycles); else passed++;
      checks++; if (clr != 1) $display("FAIL nomove%0d_clear_pulses got %0d want 1", t, clr); else passed++;
    end
    initial_mate = 1'b0;
    initial_stalemate = 1'b0;
  endtask

  task automatic test_busy_ignore();
    logic white, bw;
    int n, cyc, clr, d0;
    bit to;
    exp_t e;
    load_case(0, white, n);
    run_select(white, n, 1'b1, cyc, clr, bw, to);
    e = sb.pop_front();
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    checks++; if (to) $display("FAIL busy_timeout no done within budget"); else passed++;
    checks++; if (bw !== 1'b1) $display("FAIL busy_level got %b want 1", bw); else passed++;
    checks++; if (best_index !== e.idx) $display("FAIL busy_index got %0d want %0d", best_index, e.idx); else passed++;
    checks++; if (cyc != e.cycles) $display("FAIL busy_latency got %0d want %0d", cyc, e.cycles); else passed++;
    checks++; if (done_cnt != d0 || busy !== 1'b0) $display("FAIL busy_extra_run got %0d dones busy=%b want 0 and 0", done_cnt - d0, busy); else passed++;
  endtask

  task automatic test_reset_abort();
    logic white, bw;
    int n, cyc, clr, c0, d0;
    bit to;
    exp_t e;
    load_case(1, white, n);
    void'(sb.pop_front());
    @(posedge clk); #1;
    white_to_move = white; am_move_count = MPL'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    am_moves_ready = 1'b1;
    c0 = clear_cnt;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if ({am_move_index, am_clear_moves, busy, done, best_valid} !== '0) $display("FAIL abort_ctrl got %h want 0", {am_move_index, am_clear_moves, busy, done, best_valid}); else passed++;
    checks++; if ({best_index, best_uci, best_eval, result} !== '0) $display("FAIL abort_best got %h want 0", {best_index, best_uci, best_eval, result}); else passed++;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    am_moves_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (clear_cnt != c0) $display("FAIL abort_clear got %0d pulses want 0", clear_cnt - c0); else passed++;
    checks++; if (done_cnt != d0 || busy !== 1'b0) $display("FAIL abort_idle got dones=%0d busy=%b want 0 and 0", done_cnt - d0, busy); else passed++;
    load_case(2, white, n);
    run_select(white, n, 1'b0, cyc, clr, bw, to);
    e = sb.pop_front();
    checks++; if (to) $display("FAIL after_abort_timeout no done within budget"); else passed++;
    checks++; if (best_index !== e.idx || best_eval !== e.ev) $display("FAIL after_abort_best got %0d/%0d want %0d/%0d", best_index, best_eval, e.idx, e.ev); else passed++;
    checks++; if (clr != 1) $display("FAIL after_abort_clear got %0d want 1", clr); else passed++;
  endtask

  initial begin
    test_reset();
    test_select_cases();
    test_no_moves();
    test_busy_ignore();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
